// File: rtl/spi_pkg.sv
// ============================================================================
// Module : spi_pkg
// Brief  : Shared FSM encoding, SPI mode constants and clog2 helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_TRAIL = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_t;

   // {CPOL, CPHA}
   localparam logic [1:0] c_SPI_MODE0 = 2'b00;
   localparam logic [1:0] c_SPI_MODE1 = 2'b01;
   localparam logic [1:0] c_SPI_MODE2 = 2'b10;
   localparam logic [1:0] c_SPI_MODE3 = 2'b11;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tx_fifo.sv
// ============================================================================
// Module : spi_tx_fifo
// Brief  : Synchronous FIFO; full/empty/count all derived from a registered count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_tx_fifo
   import spi_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [clog2(DEPTH):0]    o_count
);

   localparam int c_PTR_W = clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full  = (r_count == c_CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_tx_stream.sv
// ============================================================================
// Module : spi_tx_stream
// Brief  : SPI transmit serializer with input FIFO; SPI_TX_BURST_EN keeps the
//          frame open across queued words.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_tx_stream
   import spi_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int CLK_DIV   = 2,
   parameter bit CPOL      = 1'b0,
   parameter bit CPHA      = 1'b0,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_in,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic             o_out,
   output logic             o_clk_out,
   output logic             o_en_out,
   output logic             o_sent,
   output logic             o_busy
);

   localparam int c_DIV_W = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
   localparam int c_H_W   = clog2(2 * WIDTH);
   localparam int c_CNT_W = clog2(DEPTH) + 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
   localparam logic [c_H_W-1:0]   c_H_LAST   = c_H_W'(2 * WIDTH - 1);

   spi_state_t          r_state;
   logic [c_DIV_W-1:0]  r_div;
   logic [c_H_W-1:0]    r_h;
   logic [WIDTH-1:0]    r_sh;

   logic                w_tick;
   logic                w_bit;
   logic [WIDTH-1:0]    w_sh_next;
   logic                w_shift;
   logic                w_burst;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [WIDTH-1:0]    w_fifo_data;
   logic [c_CNT_W-1:0]  w_count;

   spi_tx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (i_in_valid),
      .i_data  (i_in),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

`ifdef SPI_TX_BURST_EN
   assign w_burst = 1'b1;
`else
   assign w_burst = 1'b0;
`endif

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_bit     = r_sh[WIDTH-1];
         assign w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign w_bit     = r_sh[0];
         assign w_sh_next = {1'b0, r_sh[WIDTH-1:1]};
      end
   endgenerate

   assign w_tick = (r_div == c_DIV_LAST);

   // Advance to the next bit at the end of the half-period before each launch edge;
   // the final bit is never shifted out so TRAIL keeps driving it.
   assign w_shift = CPHA ? (!r_h[0] && (r_h != '0)) : (r_h[0] && (r_h != c_H_LAST));

   assign w_pop = !w_empty &&
                  ((r_state == ST_IDLE) ||
                   ((r_state == ST_TRAIL) && w_tick && w_burst));

   assign o_in_ready = ~w_full;
   assign o_busy     = (r_state != ST_IDLE) || (w_count != '0);

   // Pin outputs are registered from the state held in the current cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_div     <= '0;
         r_h       <= '0;
         r_sh      <= '0;
         o_out     <= 1'b0;
         o_clk_out <= CPOL;
         o_en_out  <= 1'b0;
         o_sent    <= 1'b0;
      end else begin
         o_out     <= 1'b0;
         o_clk_out <= CPOL;
         o_en_out  <= 1'b0;
         o_sent    <= 1'b0;
         r_div     <= w_tick ? '0 : r_div + 1'b1;
         case (r_state)
            ST_IDLE: begin
               r_div <= '0;
               if (!w_empty) begin
                  r_sh    <= w_fifo_data;
                  r_state <= ST_LEAD;
               end
            end
            ST_LEAD: begin
               o_en_out <= 1'b1;
               o_out    <= w_bit;
               if (w_tick) begin
                  r_h     <= '0;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               o_en_out  <= 1'b1;
               o_out     <= w_bit;
               o_clk_out <= CPOL ^ r_h[0];
               if (w_tick) begin
                  if (w_shift) r_sh <= w_sh_next;
                  if (r_h == c_H_LAST) r_state <= ST_TRAIL;
                  else                 r_h     <= r_h + 1'b1;
               end
            end
            ST_TRAIL: begin
               o_en_out <= 1'b1;
               o_out    <= w_bit;
               if (w_tick) begin
                  o_sent <= 1'b1;
                  if (w_burst && !w_empty) begin
                     r_sh    <= w_fifo_data;
                     r_h     <= '0;
                     r_state <= ST_SHIFT;
                  end else begin
                     r_state <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (w_tick) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_tx_stream.sv
// ============================================================================
// Module : tb_spi_tx_stream
// Brief  : Directed bench: mode 0 / mode 3 / LSB-first instances, FIFO fill, reset abort.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_tx_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  a_in = '0, b_in = '0;
   logic [11:0] c_in = '0;
   logic a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
   logic a_rdy, a_out, a_sclk, a_en, a_sent, a_busy;
   logic b_rdy, b_out, b_sclk, b_en, b_sent, b_busy;
   logic c_rdy, c_out, c_sclk, c_en, c_sent, c_busy;

   spi_tx_stream #(.WIDTH(8), .DEPTH(4), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .i_in(a_in), .i_in_valid(a_valid), .o_in_ready(a_rdy),
      .o_out(a_out), .o_clk_out(a_sclk), .o_en_out(a_en), .o_sent(a_sent), .o_busy(a_busy));

   spi_tx_stream #(.WIDTH(8), .DEPTH(4), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .i_in(b_in), .i_in_valid(b_valid), .o_in_ready(b_rdy),
      .o_out(b_out), .o_clk_out(b_sclk), .o_en_out(b_en), .o_sent(b_sent), .o_busy(b_busy));

   spi_tx_stream #(.WIDTH(12), .DEPTH(2), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0)) u_c (
      .clk(clk), .rst_n(rst_n), .i_in(c_in), .i_in_valid(c_valid), .o_in_ready(c_rdy),
      .o_out(c_out), .o_clk_out(c_sclk), .o_en_out(c_en), .o_sent(c_sent), .o_busy(c_busy));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitors append only; tests index from sizes saved before each stimulus.
   logic a_sclk_q = 1'b0, a_en_q = 1'b0;
   logic a_bits[$];
   int   a_bit_t[$], a_en_len[$], a_gap[$], a_rise_t[$], a_sent_t[$];
   int   a_run = 0, a_low = 0;

   always @(negedge clk) begin
      if (a_en && a_sclk && !a_sclk_q) begin
         a_bits.push_back(a_out);
         a_bit_t.push_back(cyc);
      end
      if (a_en) a_run++;
      else if (a_en_q) begin a_en_len.push_back(a_run); a_run = 0; end
      if (!a_en) a_low++;
      else if (!a_en_q) begin a_gap.push_back(a_low); a_rise_t.push_back(cyc); a_low = 0; end
      if (a_sent) a_sent_t.push_back(cyc);
      a_sclk_q = a_sclk;
      a_en_q   = a_en;
   end

   logic b_sclk_q = 1'b1, b_en_q = 1'b0, b_out_q = 1'b0;
   logic b_bits[$];
   int   b_viol = 0, b_sent_n = 0;

   always @(negedge clk) begin
      if (b_en && b_sclk && !b_sclk_q) b_bits.push_back(b_out);
      if (b_en && b_en_q && (b_out != b_out_q) && !(b_sclk_q && !b_sclk)) b_viol++;
      if (b_sent) b_sent_n++;
      b_sclk_q = b_sclk;
      b_en_q   = b_en;
      b_out_q  = b_out;
   end

   logic c_sclk_q = 1'b0, c_en_q = 1'b0;
   logic c_bits[$];
   int   c_en_len[$];
   int   c_run = 0, c_sent_n = 0;

   always @(negedge clk) begin
      if (c_en && c_sclk && !c_sclk_q) c_bits.push_back(c_out);
      if (c_en) c_run++;
      else if (c_en_q) begin c_en_len.push_back(c_run); c_run = 0; end
      if (c_sent) c_sent_n++;
      c_sclk_q = c_sclk;
      c_en_q   = c_en;
   end

   function automatic logic [31:0] get_word(input logic q[$], input int base, input int n);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < n; i++) w = {w[30:0], (base + i < q.size()) ? q[base + i] : 1'b0};
      return w;
   endfunction

   task automatic wait_idle(input string tag, input int limit);
      int n;
      n = 0;
      while ((a_busy || b_busy || c_busy) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, {31'd0, n >= limit}, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic push_a(input logic [7:0] d, output int h);
      @(negedge clk);
      a_in = d; a_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      h = cyc; a_valid = 1'b0;
   endtask

   int h, ab, ae, ag, as, bb, bs, cb, ce, cs, ones;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_a_out",   {31'd0, a_out},  32'd0);
      check_val("rst_a_sclk",  {31'd0, a_sclk}, 32'd0);
      check_val("rst_b_sclk",  {31'd0, b_sclk}, 32'd1);
      check_val("rst_a_en",    {31'd0, a_en},   32'd0);
      check_val("rst_a_sent",  {31'd0, a_sent}, 32'd0);
      check_val("rst_a_ready", {31'd0, a_rdy},  32'd1);
      check_val("rst_a_busy",  {31'd0, a_busy}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Mode 0 single word
      ab = a_bits.size(); ae = a_en_len.size(); ag = a_rise_t.size(); as = a_sent_t.size();
      push_a(8'hA5, h);
      wait_idle("t1_timeout", 200);
      check_val("t1_en_rise",    a_rise_t[ag] - h, 32'd2);
      check_val("t1_first_edge", a_bit_t[ab] - h,  32'd6);
      check_val("t1_nbits",      a_bits.size() - ab, 32'd8);
      check_val("t1_data",       get_word(a_bits, ab, 8), 32'hA5);
      check_val("t1_en_len",     a_en_len[ae], 32'd36);
      check_val("t1_sent_n",     a_sent_t.size() - as, 32'd1);
      check_val("t1_sent_pos",   a_sent_t[as] - a_rise_t[ag], 32'd35);

      // Mode 3 single word
      bb = b_bits.size(); bs = b_sent_n;
      check_val("t2_idle_sclk", {31'd0, b_sclk}, 32'd1);
      @(negedge clk);
      b_in = 8'h3C; b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      wait_idle("t2_timeout", 200);
      check_val("t2_nbits",      b_bits.size() - bb, 32'd8);
      check_val("t2_data",       get_word(b_bits, bb, 8), 32'h3C);
      check_val("t2_change_edge", b_viol, 32'd0);
      check_val("t2_sclk_after", {31'd0, b_sclk}, 32'd1);
      check_val("t2_sent_n",     b_sent_n - bs, 32'd1);

      // FIFO fill: 5 accepted (first pops at once), 6th dropped
      ab = a_bits.size(); ae = a_en_len.size(); ag = a_gap.size(); as = a_sent_t.size();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_val($sformatf("t3_ready%0d", i), {31'd0, a_rdy}, {31'd0, i < 5});
         a_in = 8'(8'h11 * (i + 1));
         a_valid = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      a_valid = 1'b0;
      wait_idle("t3_timeout", 600);
      check_val("t3_nbits", a_bits.size() - ab, 32'd40);
      for (int i = 0; i < 5; i++)
         check_val($sformatf("t3_word%0d", i), get_word(a_bits, ab + 8 * i, 8), 32'(8'h11 * (i + 1)));
      check_val("t3_sent_n", a_sent_t.size() - as, 32'd5);
`ifdef SPI_TX_BURST_EN
      check_val("t3_frames",  a_en_len.size() - ae, 32'd1);
      check_val("t3_spacing", a_sent_t[as + 1] - a_sent_t[as], 32'd34);
`else
      check_val("t3_frames",  a_en_len.size() - ae, 32'd5);
      check_val("t3_gap",     a_gap[ag + 1], 32'd3);
      check_val("t3_spacing", a_sent_t[as + 1] - a_sent_t[as], 32'd39);
`endif

      // LSB first, WIDTH=12, CLK_DIV=1
      cb = c_bits.size(); ce = c_en_len.size(); cs = c_sent_n;
      @(negedge clk);
      c_in = 12'h001; c_valid = 1'b1;
      @(negedge clk);
      c_valid = 1'b0;
      wait_idle("t4_timeout", 200);
      check_val("t4_nbits", c_bits.size() - cb, 32'd12);
      check_val("t4_first", {31'd0, (cb < c_bits.size()) ? c_bits[cb] : 1'b0}, 32'd1);
      ones = 0;
      for (int i = 1; i < 12; i++) if (cb + i < c_bits.size() && c_bits[cb + i]) ones++;
      check_val("t4_rest",   ones, 32'd0);
      check_val("t4_en_len", c_en_len[ce], 32'd26);
      check_val("t4_sent_n", c_sent_n - cs, 32'd1);

      // Reset in the middle of SHIFT
      as = a_sent_t.size();
      push_a(8'hA5, h);
      repeat (12) @(negedge clk);
      check_val("t5_in_frame", {31'd0, a_en}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("t5_out",   {31'd0, a_out},  32'd0);
      check_val("t5_sclk",  {31'd0, a_sclk}, 32'd0);
      check_val("t5_en",    {31'd0, a_en},   32'd0);
      check_val("t5_ready", {31'd0, a_rdy},  32'd1);
      check_val("t5_busy",  {31'd0, a_busy}, 32'd0);
      check_val("t5_nosent", a_sent_t.size() - as, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      ab = a_bits.size(); as = a_sent_t.size();
      push_a(8'h5A, h);
      wait_idle("t5_timeout", 200);
      check_val("t5_data",   get_word(a_bits, ab, 8), 32'h5A);
      check_val("t5_sent_n", a_sent_t.size() - as, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
